// File: rtl/brent_kung_adder_pkg.sv
// Shared constants and elaboration helpers for the Brent-Kung adder.
package brent_kung_adder_pkg;

  localparam int BK_DEFAULT_WIDTH = 64;

  // True when n is a power of two no smaller than 2 (the tree needs full levels).
  function automatic bit bk_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/brent_kung_adder_prefix_cell.sv
// Brent-Kung prefix operator: merges a high (G,P) group with the adjacent low group.
module bk_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  // Merged group generates if the high part generates, or propagates a low generate.
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/brent_kung_adder.sv
// Registered WIDTH-bit unsigned adder, carry-in 0, carries from a Brent-Kung prefix tree.
module brent_kung_adder
  import brent_kung_adder_pkg::*;
#(
  parameter int WIDTH = BK_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LOGW = $clog2(WIDTH);

  if (!bk_is_pow2(WIDTH)) begin : g_bad_width
    $error("brent_kung_adder: WIDTH must be a power of two >= 2");
  end

  // Up-sweep: level 0 holds per-bit generate/propagate; level l builds groups of 2^l bits
  // ending at every index i with (i+1) a multiple of 2^l. Each level lives in its own
  // generate scope so no signal is both read and written across levels.
  for (genvar l = 0; l <= LOGW; l++) begin : g_up
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : g_pre
      assign g = a & b;
      assign p = a ^ b;
    end else begin : g_lvl
      localparam int SPAN = 1 << l;
      localparam int HALF = SPAN / 2;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % SPAN) == 0) begin : g_cell
          bk_prefix_cell u_cell (
            .g_hi  (g_up[l-1].g[i]),
            .p_hi  (g_up[l-1].p[i]),
            .g_lo  (g_up[l-1].g[i-HALF]),
            .p_lo  (g_up[l-1].p[i-HALF]),
            .g_out (g[i]),
            .p_out (p[i])
          );
        end else begin : g_pass
          assign g[i] = g_up[l-1].g[i];
          assign p[i] = g_up[l-1].p[i];
        end
      end
    end
  end

  // Down-sweep: stage s works at tree level l = LOGW - s and fills in the prefixes the
  // up-sweep skipped, so after the last stage every bit i holds the group 0..i.
  for (genvar s = 0; s < LOGW; s++) begin : g_dn
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (s == 0) begin : g_root
      assign g = g_up[LOGW].g;
      assign p = g_up[LOGW].p;
    end else begin : g_lvl
      localparam int LVL  = LOGW - s;
      localparam int SPAN = 1 << LVL;
      localparam int HALF = SPAN / 2;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % SPAN) == HALF) && (i >= SPAN)) begin : g_cell
          bk_prefix_cell u_cell (
            .g_hi  (g_dn[s-1].g[i]),
            .p_hi  (g_dn[s-1].p[i]),
            .g_lo  (g_dn[s-1].g[i-HALF]),
            .p_lo  (g_dn[s-1].p[i-HALF]),
            .g_out (g[i]),
            .p_out (p[i])
          );
        end else begin : g_pass
          assign g[i] = g_dn[s-1].g[i];
          assign p[i] = g_dn[s-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] g_pre_all;
  logic [WIDTH-1:0] p_bit;
  logic             unused_p_pre_all;

  assign g_pre_all = g_dn[LOGW-1].g;
  assign p_bit     = g_up[0].p;
  // The block-propagate prefixes have no consumer once carry-in is fixed at 0.
  assign unused_p_pre_all = ^g_dn[LOGW-1].p;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  // Sum bit i is the bit propagate XOR the carry into bit i (c_0 = 0, c_{i+1} = G[0..i]).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_d  = '0;
    cout_d = 1'b0;
    sum_d  = p_bit ^ {g_pre_all[WIDTH-2:0], 1'b0};
    cout_d = g_pre_all[WIDTH-1];
  end

  // Result register: cleared asynchronously, otherwise loads every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_brent_kung_adder.sv
// Self-checking bench for brent_kung_adder: directed corners plus a randomized stream
// compared every cycle against a plain-arithmetic registered-sum model.
module tb_brent_kung_adder;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  logic [W:0] model_q;

  brent_kung_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the registered value is simply the full-width sum of the sampled operands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_q <= '0;
    else        model_q <= {1'b0, a} + {1'b0, b};
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Operand pairs biased toward long carry/propagate chains as well as uniform values.
  task automatic pick_operands(output logic [W-1:0] x, output logic [W-1:0] y);
    case ($urandom_range(0, 3))
      0: begin x = rnd64(); y = rnd64(); end
      1: begin x = rnd64(); y = ~x + W'($urandom_range(0, 2)); end
      2: begin x = '1 - W'($urandom_range(0, 3)); y = W'($urandom_range(0, 7)); end
      default: begin x = rnd64() | 64'h8000_0000_0000_0000; y = rnd64() | 64'h8000_0000_0000_0000; end
    endcase
  endtask

  // Drive one pair, then check both the DUT and the model against a hand-computed value.
  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W:0] exp);
    @(posedge clk); #2;
    a = x;
    b = y;
    @(posedge clk); #1;
    check(name, {cout, sum}, exp);
    check({name, "_model"}, model_q, exp);
  endtask

  // Every-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("stream", {cout, sum}, model_q);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] x, y;
    rst_n = 1'b1;
    a = '0;
    b = '0;
    #1;
    rst_n = 1'b0;
    a = rnd64();
    b = rnd64();
    #1;
    check("reset_async", {cout, sum}, '0);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", {cout, sum}, '0);
      a = rnd64();
      b = rnd64();
    end

    // Release between edges; the next rising edge is the first capture.
    @(posedge clk); #2;
    pick_operands(x, y);
    a = x;
    b = y;
    rst_n = 1'b1;
    #1;
    check("release_before_edge", {cout, sum}, '0);
    @(posedge clk); #1;
    check("release_first_load", {cout, sum}, {1'b0, x} + {1'b0, y});
    cmp_en = 1'b1;

    directed("small_add",   64'h0000_0000_0000_000F, 64'h0000_0000_0000_0001, 65'h0_0000_0000_0000_0010);
    directed("full_chain",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h1_0000_0000_0000_0000);
    directed("all_prop",    64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 65'h0_FFFF_FFFF_FFFF_FFFF);
    directed("max_plus_max",64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
    directed("msb_plus_msb",64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000);
    directed("zero_zero",   64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 65'h0_0000_0000_0000_0000);
    directed("mid_carry",   64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h0_0000_0001_0000_0000);

    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #2;
      pick_operands(x, y);
      a = x;
      b = y;
      if (i == 5000) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", {cout, sum}, '0);
        repeat (2) begin
          @(posedge clk); #1;
          check("mid_reset_hold", {cout, sum}, '0);
          a = rnd64();
          b = rnd64();
        end
        @(posedge clk); #2;
        pick_operands(x, y);
        a = x;
        b = y;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_resume", {cout, sum}, {1'b0, x} + {1'b0, y});
      end
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
